// File: rtl/unary_add_pkg.sv
// rtl/unary_add_pkg.sv - shared width, state encoding and helpers for the unary adder driver
package unary_add_pkg;

    localparam int W = 3;

    localparam logic [W-1:0] RES_MAX = {W{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        FLUSH,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [W-1:0] max_w(input logic [W-1:0] x, input logic [W-1:0] y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/unary_add_driver_if.sv
// rtl/unary_add_driver_if.sv - host and adder-side signal bundle for the unary adder driver
interface unary_add_driver_if
    import unary_add_pkg::*;
();

    logic         start;
    logic [W-1:0] a_val;
    logic [W-1:0] b_val;
    logic         dout;
    logic         C;
    logic         A;
    logic         B;
    logic         en;
    logic         read_or_write;
    logic         busy;
    logic         done;
    logic [W:0]   sum;
    logic         err;

    // Environment view: host request plus the adder's returned pulses.
    modport master (
        output start, a_val, b_val, dout, C,
        input  A, B, en, read_or_write, busy, done, sum, err
    );

    // Driver view.
    modport slave (
        input  start, a_val, b_val, dout, C,
        output A, B, en, read_or_write, busy, done, sum, err
    );

endinterface

// File: rtl/unary_pulse_gen.sv
// rtl/unary_pulse_gen.sv - loads a count and emits that many back-to-back single-cycle pulses
module unary_pulse_gen
    import unary_add_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         pulse
);

    logic [W-1:0] remaining;

    // The first pulse is issued on the load edge itself, so remaining holds the pulses still owed after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse     <= 1'b0;
            remaining <= '0;
        end else if (load) begin
            pulse     <= (value != '0);
            remaining <= (value != '0) ? value - W'(1) : '0;
        end else if (remaining != '0) begin
            pulse     <= 1'b1;
            remaining <= remaining - W'(1);
        end else begin
            pulse     <= 1'b0;
        end
    end

endmodule

// File: rtl/unary_add_driver.sv
// rtl/unary_add_driver.sv - serialises two binary operands into the unary adder and reassembles the sum
module unary_add_driver
    import unary_add_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    unary_add_driver_if.slave  bus
);

    state_t       state;
    logic [W-1:0] drive_cnt;
    logic         flush_cnt;
    logic         drain_first;
    logic         carry;
    logic [W-1:0] residual;
    logic         en_q;
    logic         rw_q;
    logic         busy_q;
    logic         done_q;
    logic         err_q;
    logic [W:0]   sum_q;
    logic         accept;
    logic         a_pulse;
    logic         b_pulse;

    assign accept = (state == IDLE) && bus.start;

    unary_pulse_gen u_gen_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .value (bus.a_val),
        .pulse (a_pulse)
    );

    unary_pulse_gen u_gen_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .value (bus.b_val),
        .pulse (b_pulse)
    );

    assign bus.A             = a_pulse;
    assign bus.B             = b_pulse;
    assign bus.en            = en_q;
    assign bus.read_or_write = rw_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.sum           = sum_q;

    // Sequencer: drive pulses, let the adder's late carry settle, then count the drained pulses back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            drive_cnt   <= '0;
            flush_cnt   <= 1'b0;
            drain_first <= 1'b0;
            carry       <= 1'b0;
            residual    <= '0;
            en_q        <= 1'b0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sum_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        carry     <= 1'b0;
                        residual  <= '0;
                        err_q     <= 1'b0;
                        sum_q     <= '0;
                        busy_q    <= 1'b1;
                        en_q      <= 1'b1;
                        rw_q      <= 1'b0;
                        flush_cnt <= 1'b0;
                        drive_cnt <= max_w(bus.a_val, bus.b_val);
                        if ((bus.a_val == '0) && (bus.b_val == '0)) begin
                            state <= FLUSH;
                        end else begin
                            state <= DRIVE;
                        end
                    end
                end

                DRIVE: begin
                    if (bus.C) begin
                        carry <= 1'b1;
                    end
                    if (drive_cnt <= W'(1)) begin
                        state     <= FLUSH;
                        flush_cnt <= 1'b0;
                    end else begin
                        drive_cnt <= drive_cnt - W'(1);
                    end
                end

                FLUSH: begin
                    if (bus.C) begin
                        carry <= 1'b1;
                    end
                    if (flush_cnt) begin
                        state       <= DRAIN;
                        rw_q        <= 1'b1;
                        drain_first <= 1'b1;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end

                DRAIN: begin
                    drain_first <= 1'b0;
                    // The first drain cycle still sees the adder's stale read-phase output.
                    if (!drain_first) begin
                        if (bus.dout && (residual != RES_MAX)) begin
                            residual <= residual + W'(1);
                        end else begin
                            err_q  <= bus.dout;
                            state  <= DONE;
                            en_q   <= 1'b0;
                            rw_q   <= 1'b0;
                            done_q <= 1'b1;
                            sum_q  <= {carry, residual};
                        end
                    end
                end

                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
